// File: rtl/cartoon_pkg.sv
// Shared types for the raster-to-window stage: pixel/window types and FSM states.
package cartoon_pkg;

  localparam int PIXEL_W    = 24;
  localparam int WIN_PIXELS = 9;

  typedef logic [PIXEL_W-1:0] pixel_t;
  // Element 8 is the top-left neighbour, element 0 the bottom-right (row-major).
  typedef pixel_t [WIN_PIXELS-1:0] window_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    EMIT,
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/line_buffer.sv
// One row of pixels with a registered read-before-write port pair, used as a
// line delay. Contents are don't-care after reset.
module line_buffer
  import cartoon_pkg::*;
#(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pixel_t            wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output pixel_t            rd_data
);

  pixel_t mem [DEPTH];

  // NOTE: the array is deliberately left out of reset; resetting it would turn
  // the RAM into a flop bank and every entry is rewritten before it is used.
  always_ff @(posedge clk) begin
    if (en) begin
      rd_data       <= mem[rd_addr];
      mem[wr_addr]  <= wr_data;
    end
  end

endmodule

// File: rtl/window_buffer.sv
// Raster-to-3x3 window stage with downstream pixel_done handshake.
// Define WINDOW_BORDER_PASS_EN to add the border_* pass-through outputs.
module window_buffer
  import cartoon_pkg::*;
#(
  parameter  int IMG_WIDTH  = 640,
  parameter  int IMG_HEIGHT = 480,
  localparam int COL_W      = $clog2(IMG_WIDTH),
  localparam int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  pixel_t           pixel_in,
  input  logic             pixel_valid,
  input  logic             sof,
  output logic             pixel_ready,
  output window_t          pixelData,
  output logic             intensity_enable,
  input  logic             pixel_done,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             frame_done
`ifdef WINDOW_BORDER_PASS_EN
  ,
  output pixel_t           border_pixel,
  output logic [ROW_W-1:0] border_row,
  output logic [COL_W-1:0] border_col,
  output logic             border_valid
`endif
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  state_t           state;
  logic [ROW_W-1:0] row, acc_row, row_nxt;
  logic [COL_W-1:0] col, acc_col, col_nxt;
  logic             last_seen;
  logic             take, at_row_end, completes, is_last;
  pixel_t           line0_q, line1_q;
  window_t          win, win_nxt;

  assign pixel_ready = (state == IDLE) || (state == ACCEPT);
  // Non-sof pixels offered in IDLE are dropped; sof always restarts at (0,0).
  assign take       = pixel_valid && pixel_ready && (sof || state == ACCEPT);
  assign acc_row    = sof ? '0 : row;
  assign acc_col    = sof ? '0 : col;
  assign at_row_end = (acc_col == LAST_COL);
  assign col_nxt    = at_row_end ? '0 : acc_col + 1'b1;
  assign row_nxt    = at_row_end ? acc_row + 1'b1 : acc_row;
  assign completes  = (acc_row >= ROW_W'(2)) && (acc_col >= COL_W'(2));
  assign is_last    = (acc_row == LAST_ROW) && at_row_end;

  // Reads are issued one column ahead so rows r-1/r-2 of the column being
  // accepted are already registered when its pixel arrives.
  line_buffer #(.DEPTH(IMG_WIDTH)) u_line0 (
    .clk     (clk),
    .en      (take),
    .wr_addr (acc_col),
    .wr_data (pixel_in),
    .rd_addr (col_nxt),
    .rd_data (line0_q)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) u_line1 (
    .clk     (clk),
    .en      (take),
    .wr_addr (acc_col),
    .wr_data (line0_q),
    .rd_addr (col_nxt),
    .rd_data (line1_q)
  );

  assign win_nxt = {win[7], win[6], line1_q,
                    win[4], win[3], line0_q,
                    win[1], win[0], pixel_in};

  always_ff @(posedge clk) begin
    if (take) win <= win_nxt;
  end

  // NOTE: every state update here is non-blocking, so all branches read the
  // pre-edge values of row/col/state regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      row              <= '0;
      col              <= '0;
      last_seen        <= 1'b0;
      pixelData        <= '0;
      win_row          <= '0;
      win_col          <= '0;
      intensity_enable <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      intensity_enable <= 1'b0;
      frame_done       <= 1'b0;
      unique case (state)
        IDLE, ACCEPT: begin
          if (take) begin
            row       <= row_nxt;
            col       <= col_nxt;
            last_seen <= is_last;
            if (completes) begin
              state            <= EMIT;
              intensity_enable <= 1'b1;
              pixelData        <= win_nxt;
              win_row          <= acc_row - 1'b1;
              win_col          <= acc_col - 1'b1;
            end else begin
              state <= ACCEPT;
            end
          end
        end
        EMIT: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (pixel_done) begin
            if (last_seen) begin
              frame_done <= 1'b1;
              last_seen  <= 1'b0;
              row        <= '0;
              col        <= '0;
              state      <= IDLE;
            end else begin
              state <= ACCEPT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WINDOW_BORDER_PASS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      border_valid <= 1'b0;
      border_pixel <= '0;
      border_row   <= '0;
      border_col   <= '0;
    end else begin
      border_valid <= take && (acc_row == '0 || acc_row == LAST_ROW ||
                               acc_col == '0 || at_row_end);
      if (take) begin
        border_pixel <= pixel_in;
        border_row   <= acc_row;
        border_col   <= acc_col;
      end
    end
  end
`endif

endmodule

// File: tb/tb_window_buffer.sv
// Directed bench for window_buffer on a 4x4 image; pixel(r,c) = {r, c, blue}.
module tb_window_buffer;

  localparam int W = 4;
  localparam int H = 4;

  logic         tb_clk = 1'b0;
  logic         rst;
  logic [23:0]  pixel_in;
  logic         pixel_valid, sof, pixel_ready;
  logic [215:0] pixelData;
  logic         intensity_enable, pixel_done, frame_done;
  logic [1:0]   win_row, win_col;
`ifdef WINDOW_BORDER_PASS_EN
  logic [23:0]  border_pixel;
  logic [1:0]   border_row, border_col;
  logic         border_valid;
`endif

  always #5 tb_clk = ~tb_clk;

  window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk              (tb_clk),
    .rst              (rst),
    .pixel_in         (pixel_in),
    .pixel_valid      (pixel_valid),
    .sof              (sof),
    .pixel_ready      (pixel_ready),
    .pixelData        (pixelData),
    .intensity_enable (intensity_enable),
    .pixel_done       (pixel_done),
    .win_row          (win_row),
    .win_col          (win_col),
    .frame_done       (frame_done)
`ifdef WINDOW_BORDER_PASS_EN
    ,
    .border_pixel     (border_pixel),
    .border_row       (border_row),
    .border_col       (border_col),
    .border_valid     (border_valid)
`endif
  );

  typedef struct {
    int   r;
    int   c;
    logic sof;
    logic win;
    int   wr;
    int   wc;
  } vec_t;

  vec_t         vec [16];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           ie_count = 0;
  int           fd_count = 0;
  int           bv_count = 0;
  logic         resp_en  = 1'b1;
  logic [7:0]   cur_blue = 8'h5A;
  logic [215:0] held     = '0;

  task automatic check(input string name, input logic [215:0] act, input logic [215:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [23:0] pix(input int r, input int c, input logic [7:0] b);
    return {8'(r), 8'(c), b};
  endfunction

  function automatic logic [215:0] exp_window(input int r, input int c);
    logic [215:0] w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[(8 - (dr * 3 + dc)) * 24 +: 24] = pix(r + dr - 1, c + dc - 1, 8'h5A);
    return w;
  endfunction

  task automatic settle(input int n);
    repeat (n) @(negedge tb_clk);
    #1;
  endtask

  // Downstream model: pixel_done for one cycle, 9 cycles after each window.
  initial begin
    pixel_done = 1'b0;
    forever begin
      @(negedge tb_clk);
      if (intensity_enable && resp_en) begin
        repeat (9) @(posedge tb_clk);
        #1 pixel_done = 1'b1;
        @(posedge tb_clk);
        #1 pixel_done = 1'b0;
      end
    end
  end

  always @(negedge tb_clk) begin
    if (intensity_enable) ie_count++;
    if (frame_done) fd_count++;
`ifdef WINDOW_BORDER_PASS_EN
    if (border_valid) begin
      bv_count++;
      check("border_pixel", border_pixel, {6'b0, border_row, 6'b0, border_col, cur_blue});
      check("border_pos", (border_row == 0 || border_row == 2'(H - 1) ||
                           border_col == 0 || border_col == 2'(W - 1)), 1);
    end
`endif
  end

  // Present one pixel with pixel_valid high and return at the negedge after it
  // is accepted; any stall must last exactly EMIT plus the 9-cycle response.
  task automatic send(input logic [23:0] p, input logic s);
    int   waited = 0;
    logic prev_pd = 1'b0;
    pixel_in    = p;
    sof         = s;
    pixel_valid = 1'b1;
    while (!pixel_ready && waited < 200) begin
      check("hold_pixelData", pixelData, held);
      prev_pd = pixel_done;
      @(negedge tb_clk);
      waited++;
    end
    if (waited > 0) begin
      check("pixel_ready", pixel_ready, 1);
      check("stall_cycles", waited, 10);
      check("accept_after_done", prev_pd, 1);
    end
    @(posedge tb_clk);
    @(negedge tb_clk);
  endtask

  task automatic run_frame(input bit first);
    int   ie0, fd0, bv0, n;
    logic prev_pd;
    pixel_valid = 1'b0;
    settle(1);
    cur_blue = 8'h5A;
    ie0 = ie_count;
    fd0 = fd_count;
    bv0 = bv_count;
    for (int i = 0; i < 16; i++) begin
      send(pix(vec[i].r, vec[i].c, 8'h5A), vec[i].sof);
      check("intensity_enable", intensity_enable, vec[i].win);
      if (vec[i].win) begin
        held = exp_window(vec[i].wr, vec[i].wc);
        check("win_row", win_row, vec[i].wr);
        check("win_col", win_col, vec[i].wc);
        check("pixelData", pixelData, held);
        if (first && i == 10) begin
          check("first_top_left", pixelData[215:192], 24'h00005A);
          check("first_centre", pixelData[119:96], 24'h01015A);
          check("first_bot_right", pixelData[23:0], 24'h02025A);
        end
      end
    end
    pixel_valid = 1'b0;
    n = 0;
    prev_pd = 1'b0;
    while (!frame_done && n < 100) begin
      prev_pd = pixel_done;
      @(negedge tb_clk);
      n++;
    end
    check("frame_done_seen", frame_done, 1);
    check("frame_done_after_done", prev_pd, 1);
    settle(3);
    check("windows_per_frame", ie_count - ie0, 4);
    check("frame_done_pulses", fd_count - fd0, 1);
`ifdef WINDOW_BORDER_PASS_EN
    check("border_per_frame", bv_count - bv0, 12);
`endif
  endtask

  initial begin
    int ie0;
    rst         = 1'b1;
    pixel_valid = 1'b0;
    sof         = 1'b0;
    pixel_in    = '0;
    for (int i = 0; i < 16; i++) begin
      vec[i].r   = i / W;
      vec[i].c   = i % W;
      vec[i].sof = (i == 0);
      vec[i].win = (vec[i].r >= 2) && (vec[i].c >= 2);
      vec[i].wr  = vec[i].r - 1;
      vec[i].wc  = vec[i].c - 1;
    end

    // Reset values
    repeat (3) @(negedge tb_clk);
    check("rst_pixel_ready", pixel_ready, 1);
    check("rst_intensity_enable", intensity_enable, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pixelData", pixelData, 0);
    check("rst_win_row", win_row, 0);
    check("rst_win_col", win_col, 0);
    rst = 1'b0;
    settle(2);

    // IDLE drops non-sof pixels, even enough of them to reach a window centre
    ie0 = ie_count;
    cur_blue = 8'hEE;
    pixel_valid = 1'b1;
    sof = 1'b0;
    for (int i = 0; i < 12; i++) begin
      pixel_in = pix(i / W, i % W, 8'hEE);
      @(negedge tb_clk);
    end
    pixel_valid = 1'b0;
    settle(12);
    check("idle_drop_windows", ie_count - ie0, 0);
    check("idle_drop_ready", pixel_ready, 1);

    // Normal frame
    run_frame(1'b1);

    // Abort after two rows: sof on the (2,0) slot restarts the frame
    cur_blue = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      send(pix(i / W, i % W, 8'hA5), i == 0);
      check("partial_no_window", intensity_enable, 0);
    end
    run_frame(1'b0);

    // Reset while waiting for pixel_done
    resp_en = 1'b0;
    cur_blue = 8'h5A;
    for (int i = 0; i < 11; i++) send(pix(i / W, i % W, 8'h5A), i == 0);
    pixel_valid = 1'b0;
    check("pre_rst_emit", intensity_enable, 1);
    repeat (3) @(negedge tb_clk);
    check("wait_done_ready", pixel_ready, 0);
    rst = 1'b1;
    #1;
    check("async_rst_intensity_enable", intensity_enable, 0);
    check("async_rst_pixelData", pixelData, 0);
    check("async_rst_frame_done", frame_done, 0);
    check("async_rst_pixel_ready", pixel_ready, 1);
    @(negedge tb_clk);
    rst = 1'b0;
    resp_en = 1'b1;
    run_frame(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
